// File: rtl/clkdiv_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// clkdiv_cfg_arbiter
//
// Purpose
//   Owns the divide value (Count_REG) and the active-low reset (DIV_RSTn) of a
//   counter-based clock divider. The divider toggles its CLK_OUT whenever its
//   internal count equals Count_REG.
//
//   Several requesters share this one divider through a round-robin arbiter
//   with a REQ/ACK handshake. A new divide value is applied only on a rising
//   edge of the divider output. If no edge arrives within TIMEOUT cycles, the
//   update is forced. After the value changes, the divider is held in reset
//   for HOLD_CYC cycles, so it restarts cleanly from count 0 with CLK_OUT=1.
//   A request whose value equals the current one completes without touching
//   the divider.
//
// Parameters
//   NUM_REQ    number of requesters (1..8)
//   CNT_W      divide-value width, matches the divider's Count_REG
//   DEF_COUNT  divide value after reset
//   TIMEOUT    max cycles to wait for a divider rising edge (>= 2)
//   HOLD_CYC   cycles DIV_RSTn is held low per update (>= 1)
//
// Ports
//   CLK        in   system clock (the divider runs on the same clock)
//   RST        in   synchronous reset, active-high
//   REQ        in   per-requester level request
//   REQ_COUNT  in   requested divide values, slice i = [i*CNT_W +: CNT_W]
//   ACK        out  one-cycle completion pulse to the granted requester
//   TMO        out  one-cycle pulse with ACK when the update was forced
//   DIV_CLK    in   divider CLK_OUT, fed back for edge alignment
//   Count_REG  out  divide value driven to the divider
//   DIV_RSTn   out  active-low reset to the divider
//   BUSY       out  high in every state except IDLE
//   OWNER      out  index of the current or last granted requester
// -----------------------------------------------------------------------------
module clkdiv_cfg_arbiter #(
  parameter int               NUM_REQ   = 2,
  parameter int               CNT_W     = 32,
  parameter logic [CNT_W-1:0] DEF_COUNT = 1,
  parameter int               TIMEOUT   = 1024,
  parameter int               HOLD_CYC  = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*CNT_W-1:0] REQ_COUNT,
  output logic [NUM_REQ-1:0]       ACK,
  output logic                     TMO,
  input  logic                     DIV_CLK,
  output logic [CNT_W-1:0]         Count_REG,
  output logic                     DIV_RSTn,
  output logic                     BUSY,
  output logic [2:0]               OWNER
);

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYC - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_EDGE,
    S_HOLD,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [CNT_W-1:0]   new_val_q,  new_val_d;
  logic               div_rstn_q, div_rstn_d;
  logic [NUM_REQ-1:0] ack_q,      ack_d;
  logic               tmo_q,      tmo_d;
  logic               tmo_f_q,    tmo_f_d;
  logic [2:0]         owner_q,    owner_d;
  logic [2:0]         rr_q,       rr_d;
  logic [TMR_W-1:0]   timer_q,    timer_d;
  logic [HLD_W-1:0]   hold_q,     hold_d;
  logic               div_q,      div_d;

  // Arbitration result, valid only while in IDLE
  logic               gnt_found;
  logic [2:0]         gnt_idx;
  logic [CNT_W-1:0]   gnt_val;

  // A rising edge of the divider output, seen one cycle late through div_q
  logic               rise;
  assign rise = DIV_CLK & ~div_q;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: scan positions rr, rr+1, ... (with wrap) and take the
  // first requester whose REQ is set. The outer loop walks the scan order, the
  // inner loop matches the wrapped position to a constant requester index, so
  // every bit and slice select uses a constant index.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_val   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && REQ[i] &&
            ((int'(rr_q) + k == i) || (int'(rr_q) + k - NUM_REQ == i))) begin
          gnt_found = 1'b1;
          gnt_idx   = 3'(i);
          gnt_val   = REQ_COUNT[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d    = state_q;
    count_d    = count_q;
    new_val_d  = new_val_q;
    div_rstn_d = div_rstn_q;
    ack_d      = '0;
    tmo_d      = 1'b0;
    tmo_f_d    = tmo_f_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    div_d      = DIV_CLK;

    unique case (state_q)
      S_IDLE: begin
        // Releases the divider on the first edge after reset
        div_rstn_d = 1'b1;
        if (gnt_found) begin
          owner_d   = gnt_idx;
          new_val_d = gnt_val;
          tmo_f_d   = 1'b0;
          state_d   = S_GRANT;
        end
      end

      S_GRANT: begin
        if (new_val_q == count_q) begin
          // Same value: complete without disturbing the divider
          state_d = S_DONE;
        end else begin
          timer_d = '0;
          state_d = S_WAIT_EDGE;
        end
      end

      S_WAIT_EDGE: begin
        timer_d = timer_q + 1'b1;
        // A rise wins over a coinciding timeout, so TMO stays low then
        if (rise || (timer_q == TMR_LAST)) begin
          count_d    = new_val_q;
          div_rstn_d = 1'b0;
          tmo_f_d    = ~rise;
          hold_d     = '0;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (hold_q == HLD_LAST) begin
          div_rstn_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_DONE: begin
        rr_d    = (owner_q == LAST_IDX) ? 3'd0 : owner_q + 3'd1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ACK/TMO are registered, so they are loaded on the edge that enters DONE
    // and are high for exactly the DONE cycle.
    if (state_d == S_DONE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        ack_d[i] = (owner_q == 3'(i));
      end
      tmo_d = tmo_f_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every flop sampling the values from
    // before the edge, whatever order the statements are written in.
    div_q <= div_d;  // edge detector runs in and out of reset
    if (RST) begin
      state_q    <= S_IDLE;
      count_q    <= DEF_COUNT;
      new_val_q  <= DEF_COUNT;
      div_rstn_q <= 1'b0;
      ack_q      <= '0;
      tmo_q      <= 1'b0;
      tmo_f_q    <= 1'b0;
      owner_q    <= 3'd0;
      rr_q       <= 3'd0;
      timer_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      new_val_q  <= new_val_d;
      div_rstn_q <= div_rstn_d;
      ack_q      <= ack_d;
      tmo_q      <= tmo_d;
      tmo_f_q    <= tmo_f_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ACK       = ack_q;
  assign TMO       = tmo_q;
  assign Count_REG = count_q;
  assign DIV_RSTn  = div_rstn_q;
  assign BUSY      = (state_q != S_IDLE);
  assign OWNER     = owner_q;

endmodule

// File: tb/tb_clkdiv_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_cfg_arbiter
//   Self-checking bench for clkdiv_cfg_arbiter. A behavioural divider closes
//   the DIV_CLK loop. Single-requester transactions come from a vector table.
//   Reset, contention and abort are hand-written sequences. Expected ACKs are
//   queued when a request is driven and popped when ACK appears.
// -----------------------------------------------------------------------------
module tb_clkdiv_cfg_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int CNT_W    = 32;
  localparam int TIMEOUT  = 16;
  localparam int HOLD_CYC = 2;
  localparam int DEF_CNT  = 1;
  localparam int MAX_WAIT = 200;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*CNT_W-1:0] req_count = '0;
  logic [NUM_REQ-1:0]       ack;
  logic                     tmo;
  logic                     div_clk;
  logic [CNT_W-1:0]         count_reg;
  logic                     div_rstn;
  logic                     busy;
  logic [2:0]               owner;

  clkdiv_cfg_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CNT_W    (CNT_W),
    .DEF_COUNT(CNT_W'(DEF_CNT)),
    .TIMEOUT  (TIMEOUT),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ      (req),
    .REQ_COUNT(req_count),
    .ACK      (ack),
    .TMO      (tmo),
    .DIV_CLK  (div_clk),
    .Count_REG(count_reg),
    .DIV_RSTn (div_rstn),
    .BUSY     (busy),
    .OWNER    (owner)
  );

  always #5 clk = ~clk;

  // Behavioural divider: restarts at count 0 with output 1, toggles on match
  logic [CNT_W-1:0] div_cnt_m = '0;
  logic             div_out_m = 1'b1;
  logic             force_low = 1'b0;

  always @(posedge clk) begin
    if (!div_rstn) begin
      div_cnt_m <= '0;
      div_out_m <= 1'b1;
    end else if (div_cnt_m == count_reg) begin
      div_cnt_m <= '0;
      div_out_m <= ~div_out_m;
    end else begin
      div_cnt_m <= div_cnt_m + 1'b1;
    end
  end

  assign div_clk = force_low ? 1'b0 : div_out_m;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    int               id;
    logic [CNT_W-1:0] val;
    bit               force_lo;  // tie DIV_CLK low
    bit               same;      // value equals current Count_REG
    bit               tmo;       // expected TMO with ACK
    int               lat;       // expected ACK latency, 0 = phase dependent
  } vec_t;

  typedef struct {
    int               id;
    logic [CNT_W-1:0] val;
    bit               tmo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One single-requester transaction. Called at a negedge with the DUT idle.
  // Returns at a negedge with the DUT idle again.
  task automatic run_req(input vec_t v);
    exp_t             e;
    int               cyc, low, changes, upd_cyc;
    logic [CNT_W-1:0] prev;
    logic             d1, d2;
    bit               got;
    force_low = v.force_lo;
    req_count[v.id*CNT_W +: CNT_W] = v.val;
    req[v.id] = 1'b1;
    sb.push_back('{v.id, v.val, v.tmo});
    prev = count_reg;
    d1 = div_clk;
    d2 = div_clk;
    cyc = 0; low = 0; changes = 0; upd_cyc = 0; got = 1'b0;
    while (!got && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      if (!div_rstn) low++;
      if (count_reg !== prev) begin
        changes++;
        upd_cyc = cyc;
        // DIV_CLK was 0 then 1 on the two cycles before the update
        if (!v.tmo) check("update_after_rise", {62'd0, d2, d1}, 64'b01);
        prev = count_reg;
      end
      d2 = d1;
      d1 = div_clk;
      if (ack != '0) got = 1'b1;
    end
    check("ack_seen", got, 1);
    if (got) begin
      e = sb.pop_front();
      check("ack_onehot", ack, 1 << e.id);
      check("owner", owner, e.id);
      check("count_reg", count_reg, e.val);
      check("tmo", tmo, e.tmo);
      check("update_count", changes, v.same ? 0 : 1);
      check("rstn_low_cycles", low, v.same ? 0 : HOLD_CYC);
      if (!v.same) check("divider_restart", div_out_m, 1);
      if (v.lat != 0) check("latency", cyc, v.lat);
      if (v.tmo) check("timeout_update_cycle", upd_cyc, 2 + TIMEOUT);
    end else begin
      sb.delete();
    end
    req[v.id] = 1'b0;
    @(negedge clk);
    check("ack_pulse_width", ack, 0);
    check("busy_after_done", busy, 0);
    force_low = 1'b0;
  endtask

  // Cycles between two consecutive DIV_CLK toggles
  task automatic half_period(output int n, output bit ok);
    logic prev;
    int   guard;
    ok = 1'b0;
    n = 0;
    guard = 0;
    prev = div_clk;
    while (div_clk == prev && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    prev = div_clk;
    while (div_clk == prev && guard < 100) begin
      @(negedge clk);
      guard++;
      n++;
    end
    ok = (guard < 100);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vecs[6];

  initial begin
    int   hp;
    bit   ok;
    int   cyc;
    bit   got;
    int   exp_rr;
    exp_t e;

    //         id  value    force same tmo lat
    vecs[0] = '{0, 32'd5, 1'b0, 1'b0, 1'b0, 0};   // single change 1 -> 5
    vecs[1] = '{1, 32'd5, 1'b0, 1'b1, 1'b0, 2};   // same value
    vecs[2] = '{0, 32'd0, 1'b0, 1'b0, 1'b0, 0};   // change to 0 (legal)
    vecs[3] = '{1, 32'd0, 1'b0, 1'b1, 1'b0, 2};   // same value 0
    vecs[4] = '{0, 32'd3, 1'b1, 1'b0, 1'b1, 2 + TIMEOUT + HOLD_CYC}; // forced
    vecs[5] = '{1, 32'd2, 1'b0, 1'b0, 1'b0, 0};   // change after timeout

    // ---- T1: reset for 3 cycles ----
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_count", count_reg, DEF_CNT);
      check("rst_div_rstn", div_rstn, 0);
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
    end
    check("rst_owner", owner, 0);
    check("rst_tmo", tmo, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstn_release", div_rstn, 1);
    check("idle_busy", busy, 0);

    // ---- T2/T3/T5: table-driven single-requester transactions ----
    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i]);
      if (i == 0) begin
        // Divide value 5 -> output toggles every 6 cycles
        half_period(hp, ok);
        check("half_period_ok", ok, 1);
        check("half_period_5", hp, 6);
      end
    end
    exp_rr = (vecs[5].id + 1) % NUM_REQ;

    // ---- T4: contention, both requests kept up ----
    req_count[0 +: CNT_W]     = 32'd3;
    req_count[CNT_W +: CNT_W] = 32'd7;
    for (int k = 0; k < 4; k++) begin
      e.id  = (exp_rr + k) % NUM_REQ;
      e.val = (e.id == 0) ? 32'd3 : 32'd7;
      e.tmo = 1'b0;
      sb.push_back(e);
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < MAX_WAIT) begin
        @(negedge clk);
        cyc++;
        if (ack != '0) got = 1'b1;
      end
      check("rr_ack_seen", got, 1);
      if (!got) break;
      e = sb.pop_front();
      check("rr_ack_onehot", ack, 1 << e.id);
      check("rr_owner", owner, e.id);
      check("rr_count_reg", count_reg, e.val);
      req = (k == 3) ? 2'b00 : (req & ~ack);
      @(negedge clk);
      check("rr_ack_pulse", ack, 0);
      if (k != 3) req = 2'b11;
    end
    sb.delete();
    check("rr_idle", busy, 0);

    // ---- T6: reset while holding the divider in reset ----
    req_count[0 +: CNT_W] = 32'd9;
    req[0] = 1'b1;
    cyc = 0;
    while (div_rstn && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      check("abort_no_early_ack", ack, 0);
    end
    check("abort_reached_hold", div_rstn, 0);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("abort_count", count_reg, DEF_CNT);
    check("abort_div_rstn", div_rstn, 0);
    check("abort_ack", ack, 0);
    check("abort_busy", busy, 0);
    check("abort_owner", owner, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_rstn_release", div_rstn, 1);
    check("abort_ack_after", ack, 0);
    run_req('{0, 32'd9, 1'b0, 1'b0, 1'b0, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
